nonrestoring_divider: RTL



---
 rtl/nrdiv_pkg.sv | 17 +
 rtl/nrdiv_datapath.sv | 58 +++++
 rtl/nonrestoring_divider.sv | 114 +++++++++++
 3 files changed

// File: rtl/nrdiv_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encoding and
// the iteration-counter width helper.
package nrdiv_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIter    = 2'd1,
    StCorrect = 2'd2,
    StDone    = 2'd3
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/nrdiv_datapath.sv
// A/Q/M registers of the non-restoring divider: load, one shift+add/sub step
// per strobe, and the final remainder restore.
module nrdiv_datapath
  import nrdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             correct_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH:0]   a_q, a_d, a_sh, a_step, a_fix, m_ext;
  logic [WIDTH-1:0] q_q, q_d, m_q, m_d;

  always_comb begin
    m_ext  = {1'b0, m_q};
    a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    // Sign of the partial remainder selects add or subtract.
    a_step = a_q[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    a_fix  = a_q[WIDTH] ? (a_q + m_ext) : a_q;
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    if (load_i) begin
      a_d = '0;
      q_d = dividend_i;
      m_d = divisor_i;
    end else if (step_i) begin
      a_d = a_step;
      q_d = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
    end else if (correct_i) begin
      a_d = a_fix;
    end
  end

  assign quo_o = q_q;
  assign rem_o = a_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
    end
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned non-restoring divider: control FSM, iteration counter
// and held result registers around nrdiv_datapath.
module nonrestoring_divider
  import nrdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = count_width(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0] dp_quo, dp_rem;
  logic             load, step, correct;

  nrdiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .step_i    (step),
    .correct_i (correct),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .quo_o     (dp_quo),
    .rem_o     (dp_rem)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    load    = 1'b0;
    step    = 1'b0;
    correct = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            quo_d   = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            load    = 1'b1;
            count_d = '0;
            dbz_d   = 1'b0;
            state_d = StIter;
          end
        end
      end
      StIter: begin
        step    = 1'b1;
        count_d = count_q + CntW'(1);
        if (count_q == LastIter) state_d = StCorrect;
      end
      StCorrect: begin
        correct = 1'b1;
        quo_d   = dp_quo;
        rem_d   = dp_rem;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Flags are registered from the next state so they are pure flop outputs.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule
